// File: rtl/bpsk_pkg.sv
// Shared definitions for the BPSK front-end: fixed-point widths, scheduler defaults
// and the IQ multiply scheduler state encoding.
package bpsk_pkg;

  localparam int SMP_W     = 32;  // signed 8.24 samples and NCO references
  localparam int SMP_FRAC  = 24;
  localparam int PROD_W    = 32;  // signed 16.16 products
  localparam int PROD_FRAC = 16;
  localparam int DROP_W    = 16;

  localparam int MUL_LAT_DEF = 2;
  localparam int TIMEOUT_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE_I = 2'd1,
    ST_ISSUE_Q = 2'd2,
    ST_COLLECT = 2'd3
  } sched_state_t;

endpackage

// File: rtl/sched_timer.sv
// Per-operation watchdog (restarted on every result) and the post-reset window
// during which late results from an aborted operation are flushed silently.
module sched_timer
  import bpsk_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_run,
  input  logic i_restart,
  output logic o_expire,
  output logic o_flush
);

  localparam int LIMIT = MUL_LAT + TIMEOUT;
  localparam int TW    = $clog2(LIMIT + 1);
  localparam int FW    = $clog2(MUL_LAT + 2);

  logic [TW-1:0] r_tmo_cnt;
  logic [FW-1:0] r_flush_cnt;
  logic          r_flush;

  // Counts cycles spent busy since issue or since the last result.
  always_ff @(posedge clk) begin
    if (reset || !i_run || i_restart) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + TW'(1);
    end
  end

  assign o_expire = i_run && !i_restart && (r_tmo_cnt == TW'(LIMIT - 1));

  // Open for the first MUL_LAT+1 cycles after reset is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flush     <= 1'b1;
      r_flush_cnt <= '0;
    end else if (r_flush) begin
      r_flush_cnt <= r_flush_cnt + FW'(1);
      if (r_flush_cnt == FW'(MUL_LAT)) begin
        r_flush <= 1'b0;
      end
    end
  end

  assign o_flush = r_flush;

endmodule

// File: rtl/iq_mult_sched.sv
// Schedules the I and Q arm products of one ADC sample onto a shared external multiplier:
// two back-to-back operand beats, two collected results, sticky fault on protocol errors.
module iq_mult_sched
  import bpsk_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              smp_valid,
  input  logic [SMP_W-1:0]  adc,
  input  logic [SMP_W-1:0]  nco_cos,
  input  logic [SMP_W-1:0]  nco_sin,
  output logic              smp_ready,
  output logic [SMP_W-1:0]  mul_a,
  output logic [SMP_W-1:0]  mul_b,
  output logic              mul_go,
  input  logic              mul_done,
  input  logic [PROD_W-1:0] mul_p,
  output logic [PROD_W-1:0] i_out,
  output logic [PROD_W-1:0] q_out,
  output logic              iq_valid,
  output logic              busy,
  output logic              err,
  output logic [DROP_W-1:0] drop_cnt
);

  sched_state_t      r_state;
  sched_state_t      w_state_nxt;
  logic [1:0]        r_done_cnt;
  logic [SMP_W-1:0]  r_sin;
  logic              r_mul_go;
  logic [SMP_W-1:0]  r_mul_a;
  logic [SMP_W-1:0]  r_mul_b;
  logic [PROD_W-1:0] r_i_out;
  logic [PROD_W-1:0] r_q_out;
  logic              r_iq_valid;
  logic              r_err;
  logic [DROP_W-1:0] r_drop_cnt;

  logic              w_idle;
  logic              w_accept;
  logic              w_done_ok;
  logic              w_done_extra;
  logic              w_done_stray;
  logic              w_complete;
  logic              w_expire;
  logic              w_flush;
  logic              w_timeout;
  logic              w_go_nxt;
  logic [SMP_W-1:0]  w_a_nxt;
  logic [SMP_W-1:0]  w_b_nxt;

  assign w_idle       = (r_state == ST_IDLE);
  assign w_accept     = smp_valid && w_idle;
  assign w_done_ok    = mul_done && !w_idle && (r_done_cnt != 2'd2);
  assign w_done_extra = mul_done && !w_idle && (r_done_cnt == 2'd2);
  assign w_done_stray = mul_done && w_idle && !w_flush;
  // COLLECT lingers one cycle after the second result so iq_valid and IDLE never overlap.
  assign w_complete   = (r_state == ST_COLLECT) && (r_done_cnt == 2'd2);
  assign w_timeout    = w_expire && !w_complete;

  sched_timer #(
    .MUL_LAT (MUL_LAT),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_run     (!w_idle),
    .i_restart (w_done_ok),
    .o_expire  (w_expire),
    .o_flush   (w_flush)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept) w_state_nxt = ST_ISSUE_I;
      ST_ISSUE_I: w_state_nxt = w_timeout ? ST_IDLE : ST_ISSUE_Q;
      ST_ISSUE_Q: w_state_nxt = w_timeout ? ST_IDLE : ST_COLLECT;
      ST_COLLECT: if (w_complete || w_timeout) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand beats are set up one cycle ahead so mul_go/mul_a/mul_b leave a register.
  always_comb begin
    w_go_nxt = 1'b0;
    w_a_nxt  = r_mul_a;
    w_b_nxt  = r_mul_b;
    if (w_accept) begin
      w_go_nxt = 1'b1;
      w_a_nxt  = adc;
      w_b_nxt  = nco_cos;
    end else if ((r_state == ST_ISSUE_I) && !w_timeout) begin
      w_go_nxt = 1'b1;
      w_b_nxt  = r_sin;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mul_go   <= 1'b0;
      r_mul_a    <= '0;
      r_mul_b    <= '0;
      r_sin      <= '0;
      r_done_cnt <= '0;
      r_i_out    <= '0;
      r_q_out    <= '0;
      r_iq_valid <= 1'b0;
      r_err      <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_mul_go <= w_go_nxt;
      r_mul_a  <= w_a_nxt;
      r_mul_b  <= w_b_nxt;
      if (w_accept) begin
        r_sin <= nco_sin;
      end
      if (w_state_nxt == ST_IDLE) begin
        r_done_cnt <= '0;
      end else if (w_done_ok) begin
        r_done_cnt <= r_done_cnt + 2'd1;
      end
      if (w_done_ok && (r_done_cnt == 2'd0)) begin
        r_i_out <= mul_p;
      end
      if (w_done_ok && (r_done_cnt == 2'd1)) begin
        r_q_out <= mul_p;
      end
      r_iq_valid <= w_done_ok && (r_done_cnt == 2'd1);
      if (w_timeout || w_done_extra || w_done_stray) begin
        r_err <= 1'b1;
      end
      if (smp_valid && !w_idle && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + DROP_W'(1);
      end
    end
  end

  assign smp_ready = w_idle;
  assign busy      = !w_idle;
  assign mul_go    = r_mul_go;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign i_out     = r_i_out;
  assign q_out     = r_q_out;
  assign iq_valid  = r_iq_valid;
  assign err       = r_err;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: doc/iq_mult_sched.md
IQ_MULT_SCHED -- requirements
Module: iq_mult_sched

Interface
REQ-001 SHALL have parameter MUL_LAT, default 2: cycles from mul_go to mul_done of the shared multiplier.
REQ-002 SHALL have parameter TIMEOUT, default 8: maximum cycles COLLECT waits for each mul_done.
REQ-003 SHALL have port clk  in  1: rising-edge clock, sole clock domain.
REQ-004 SHALL have port reset  in  1: reset, synchronous, active-high.
REQ-005 SHALL have ports smp_valid  in  1: ADC sample strobe; adc  in  32: sample, signed 8.24.
REQ-006 SHALL have ports nco_cos, nco_sin  in  32 each: NCO I/Q arm references, signed 8.24, sampled with adc.
REQ-007 SHALL have port smp_ready  out  1: sample acceptance.
REQ-008 SHALL have ports mul_a, mul_b  out  32 each: operands to the shared multiplier; mul_go  out  1: operand strobe.
REQ-009 SHALL have ports mul_done  in  1: result strobe; mul_p  in  32: signed 16.16 product.
REQ-010 SHALL have ports i_out, q_out  out  32 each: arm products, signed 16.16; iq_valid  out  1: result pulse.
REQ-011 SHALL have ports busy  out  1; err  out  1: sticky fault; drop_cnt  out  16: dropped-sample count.

Function
REQ-012 SHALL accept a sample only when smp_valid=1 and smp_ready=1; smp_ready=1 only in state IDLE.
REQ-013 SHALL implement states IDLE, ISSUE_I, ISSUE_Q, COLLECT: IDLE->ISSUE_I on accept; ISSUE_I->ISSUE_Q; ISSUE_Q->COLLECT; COLLECT->IDLE on second mul_done or timeout.
REQ-014 SHALL latch adc, nco_cos and nco_sin on the accept cycle; later input changes SHALL NOT affect the operation.
REQ-015 SHALL drive registered mul_go=1 with mul_a=adc, mul_b=nco_cos for exactly one cycle (ISSUE_I), then mul_b=nco_sin for one cycle (ISSUE_Q), back-to-back.
REQ-016 SHALL hold mul_go=0 and mul_a, mul_b at last values in all other cycles.
REQ-017 SHALL capture mul_p into i_out on the first mul_done and into q_out on the second mul_done after issue, unchanged.
REQ-018 SHALL pulse iq_valid for one cycle the cycle after the second mul_done; i_out, q_out SHALL hold until the next capture.
REQ-019 Latency: accept at cycle t, mul_go at t+1 and t+2, iq_valid at t+3+MUL_LAT; throughput one sample per 3+MUL_LAT+1 cycles.
REQ-020 SHALL count mul_done pulses per operation in a 2-bit counter; a third or later done SHALL be ignored and SHALL set err.
REQ-021 SHALL run a timeout counter in ISSUE_I, ISSUE_Q and COLLECT, restarted at each mul_done; on reaching MUL_LAT+TIMEOUT without completion SHALL set err, return to IDLE, emit no iq_valid.
REQ-022 mul_done in IDLE SHALL be ignored and SHALL set err, except within MUL_LAT+1 cycles after reset deassertion (in-flight flush), when it SHALL be ignored silently.
REQ-023 smp_valid=1 while smp_ready=0 SHALL increment drop_cnt by one per cycle, saturating at 0xFFFF.
REQ-024 smp_valid coincident with the iq_valid cycle SHALL NOT be accepted (state still COLLECT); acceptance begins the following IDLE cycle.
REQ-025 busy SHALL equal (state != IDLE).
REQ-026 err SHALL remain set until reset.

Reset
REQ-027 On reset SHALL enter IDLE: smp_ready=1, mul_go=0, mul_a=mul_b=0, i_out=q_out=0, iq_valid=0, busy=0, err=0, drop_cnt=0, counters cleared.
REQ-028 Reset mid-operation SHALL abort the operation with no iq_valid; late mul_done handled per REQ-022.

Structure
REQ-029 State encoding, MUL_LAT/TIMEOUT defaults and the 8.24/16.16 width constants SHALL reside in shared package bpsk_pkg.
REQ-030 Timeout/flush counter SHALL be sub-module sched_timer; multiplier SHALL be external to this block.

Verification
REQ-031 Single sample adc=0x01000000, cos=0x00800000, sin=0xFF800000; model returns 0x00008000, 0xFFFF8000 -> i_out=0x00008000, q_out=0xFFFF8000, iq_valid at t+5.
REQ-032 smp_valid held high 20 cycles -> one result per 6 cycles, drop_cnt increments on every non-ready cycle.
REQ-033 Model never asserts mul_done -> err=1 at cycle t+1+MUL_LAT+TIMEOUT, return to IDLE, no iq_valid.
REQ-034 Reset asserted at t+2, model delivers both dones -> no iq_valid, err=0, smp_ready=1 after reset.
REQ-035 Spurious mul_done in IDLE 10 cycles after reset -> err=1; i_out, q_out unchanged.
REQ-036 drop_cnt preloaded by 65540 refused strobes -> saturates at 0xFFFF.
